// File: rtl/vec_pkg.sv
// vec_pkg: shared types and defaults for the vector load/store path and register file.
//   state_t          sequencer FSM states
//   OP_LOAD/OP_STORE command opcode values
//   VEC_ELEMS/VEC_DW default vector length and element width
package vec_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;
    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_STORE = 1'b1;
    localparam int VEC_ELEMS = 16;
    localparam int VEC_DW = 16;
endpackage

// File: rtl/vec_addr_gen.sv
// vec_addr_gen: strided memory address accumulator, modulo 2^AW.
//   clk, rst_n  clock, async active-low reset
//   load, base  load base as the current address
//   adv, stride add stride to the current address
//   addr        current address
module vec_addr_gen #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] base,
    input  logic          adv,
    input  logic [AW-1:0] stride,
    output logic [AW-1:0] addr
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) addr <= '0;
        else if (load) addr <= base;
        else if (adv) addr <= addr + stride;
endmodule

// File: rtl/vec_ldst_seq.sv
// vec_ldst_seq: moves one whole vector element by element between data memory and the register file.
//   clk, rst_n                  clock, async active-low reset
//   start, op, vreg             command strobe, 0=load 1=store, target vector register
//   base_addr, stride           element 0 address and per-element increment
//   busy, done                  command in progress, one-cycle completion pulse
//   vaddr, velem, vwe, vwdata   register-file element write port / read select
//   vrdata                      register-file read data
//   mem_addr, mem_rd, mem_wr    memory request
//   mem_wdata, mem_rdata        memory write / read data
//   mem_ready                   memory accepts the current request
module vec_ldst_seq
    import vec_pkg::*;
#(
    parameter int ELEMS = VEC_ELEMS,
    parameter int DW = VEC_DW,
    parameter int AW = 16,
    localparam int EW = $clog2(ELEMS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          op,
    input  logic [2:0]    vreg,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] stride,
    output logic          busy,
    output logic          done,
    output logic [2:0]    vaddr,
    output logic [EW-1:0] velem,
    output logic          vwe,
    output logic [DW-1:0] vwdata,
    input  logic [DW-1:0] vrdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);
    state_t state;
    logic [EW-1:0] cnt;
    logic [AW-1:0] stride_q;
    logic accept;
    logic last;

    assign accept = (mem_rd | mem_wr) & mem_ready;
    assign last = cnt == EW'(ELEMS - 1);
    // Register data flows straight to memory; gated so it reads 0 when no store is pending.
    assign mem_wdata = mem_wr ? vrdata : '0;

    vec_addr_gen #(.AW(AW)) u_addr (
        .clk(clk),
        .rst_n(rst_n),
        .load(state == IDLE && start),
        .base(base_addr),
        .adv(accept),
        .stride(stride_q),
        .addr(mem_addr)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            stride_q <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            vaddr <= '0;
            velem <= '0;
            vwe <= 1'b0;
            vwdata <= '0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
        end else begin
            vwe <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE:
                    if (start) begin
                        stride_q <= stride;
                        vaddr <= vreg;
                        velem <= '0;
                        cnt <= '0;
                        busy <= 1'b1;
                        mem_rd <= op == OP_LOAD;
                        mem_wr <= op == OP_STORE;
                        state <= op == OP_STORE ? STORE : LOAD;
                    end
                LOAD:
                    // Accepted read data is written the next cycle while the next read is already out.
                    if (accept) begin
                        vwe <= 1'b1;
                        velem <= cnt;
                        vwdata <= mem_rdata;
                        cnt <= cnt + 1'b1;
                        if (last) mem_rd <= 1'b0;
                    end else if (!mem_rd) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        state <= DONE;
                    end
                STORE:
                    if (accept) begin
                        cnt <= cnt + 1'b1;
                        velem <= cnt + 1'b1;
                        if (last) begin
                            mem_wr <= 1'b0;
                            busy <= 1'b0;
                            done <= 1'b1;
                            state <= DONE;
                        end
                    end
                DONE: state <= IDLE;
            endcase
        end
endmodule
